// File: rtl/ch101_map_pkg.sv
// Shared types and the default UK101 memory map for the CH101 registered decoder.
package ch101_map_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RAM  = 2'b00;
    localparam logic [1:0] SEL_ROM  = 2'b01;
    localparam logic [1:0] SEL_UART = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Region 0 sits in the least significant slice of every packed table.
    localparam int UK101_NREG = 5;
    localparam logic [UK101_NREG*16-1:0] UK101_REG_LO =
        {16'hF800, 16'hF000, 16'hA000, 16'h1000, 16'h0000};
    localparam logic [UK101_NREG*16-1:0] UK101_REG_HI =
        {16'hFFFF, 16'hF7FF, 16'hBFFF, 16'h7FFF, 16'h0FFF};
    localparam logic [UK101_NREG*2-1:0] UK101_REG_SEL =
        {SEL_ROM, SEL_UART, SEL_ROM, SEL_RAM, SEL_ROM};
    localparam logic [UK101_NREG*4-1:0] UK101_REG_WS =
        {4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
    localparam logic [UK101_NREG-1:0] UK101_REG_RO = 5'b10101;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_map_dec.sv
// Combinational base/limit region match; on overlap the lowest region index wins.
module mem_map_dec
    import ch101_map_pkg::*;
#(
    parameter int                       ADDR_W = 16,
    parameter int                       NREG   = UK101_NREG,
    parameter int                       IDX_W  = idx_width(NREG),
    parameter logic [NREG*ADDR_W-1:0]   REG_LO = UK101_REG_LO,
    parameter logic [NREG*ADDR_W-1:0]   REG_HI = UK101_REG_HI,
    parameter logic [NREG-1:0]          REG_RO = UK101_REG_RO
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic              ro
);

    // Scan from the top so the lowest matching index is the last assignment.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        ro  = 1'b0;
        for (int r = NREG - 1; r >= 0; r--) begin
            if ((addr >= REG_LO[r*ADDR_W +: ADDR_W]) &&
                (addr <= REG_HI[r*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = r[IDX_W-1:0];
                ro  = REG_RO[r];
            end
        end
    end

endmodule

// File: rtl/mem_map_ws.sv
// Registered 6502 address decoder with per-region wait states, read-only
// protection and a sticky fault logger for unmapped or illegal accesses.
module mem_map_ws
    import ch101_map_pkg::*;
#(
    parameter int                       ADDR_W  = 16,
    parameter int                       NREG    = UK101_NREG,
    parameter int                       SEL_W   = 2,
    parameter logic [NREG*ADDR_W-1:0]   REG_LO  = UK101_REG_LO,
    parameter logic [NREG*ADDR_W-1:0]   REG_HI  = UK101_REG_HI,
    parameter logic [NREG*SEL_W-1:0]    REG_SEL = UK101_REG_SEL,
    parameter logic [NREG*4-1:0]        REG_WS  = UK101_REG_WS,
    parameter logic [NREG-1:0]          REG_RO  = UK101_REG_RO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic              mem_we,
    output logic              mem_ready,
    output logic [SEL_W-1:0]  din_sel,
    output logic [NREG-1:0]   cs,
    output logic [ADDR_W-2:0] base_addr,
    output logic              reg_rs,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              fault_wr,
    input  logic              fault_clr
);

    localparam int               IDX_W        = idx_width(NREG);
    localparam logic [SEL_W-1:0] SEL_UNMAPPED = {SEL_W{1'b1}};

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [NREG-1:0]     cs_q, cs_d;
    logic [SEL_W-1:0]    din_sel_q, din_sel_d;
    logic [ADDR_W-2:0]   base_addr_q, base_addr_d;
    logic                reg_rs_q, reg_rs_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic                fault_wr_q, fault_wr_d;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_ro;
    logic [NREG-1:0]     hit_cs;
    logic [SEL_W-1:0]    hit_sel;
    logic [3:0]          hit_ws;
    logic                new_fault;
    logic                new_fault_wr;

    mem_map_dec #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .IDX_W  (IDX_W),
        .REG_LO (REG_LO),
        .REG_HI (REG_HI),
        .REG_RO (REG_RO)
    ) u_dec (
        .addr (mem_addr),
        .hit  (dec_hit),
        .idx  (dec_idx),
        .ro   (dec_ro)
    );

    // Per-region attribute lookup for the winning index.
    always_comb begin
        hit_cs  = '0;
        hit_sel = SEL_UNMAPPED;
        hit_ws  = '0;
        for (int r = 0; r < NREG; r++) begin
            if (dec_idx == r[IDX_W-1:0]) begin
                hit_cs[r] = 1'b1;
                hit_sel   = REG_SEL[r*SEL_W +: SEL_W];
                hit_ws    = REG_WS[r*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        cs_d         = cs_q;
        din_sel_d    = din_sel_q;
        base_addr_d  = base_addr_q;
        reg_rs_d     = reg_rs_q;
        new_fault    = 1'b0;
        new_fault_wr = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    state_d     = ACCESS;
                    base_addr_d = mem_addr[ADDR_W-2:0];
                    reg_rs_d    = mem_addr[0];
                    if (dec_hit && !(mem_we && dec_ro)) begin
                        cs_d      = hit_cs;
                        din_sel_d = hit_sel;
                        wcnt_d    = hit_ws;
                    end else begin
                        // A hit that still faults can only be a write to read-only space.
                        cs_d         = '0;
                        din_sel_d    = SEL_UNMAPPED;
                        wcnt_d       = '0;
                        new_fault    = 1'b1;
                        new_fault_wr = dec_hit;
                    end
                end
            end
            ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    state_d = DONE;
                    cs_d    = '0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cs_d    = '0;
            end
            default: begin
                state_d = IDLE;
                cs_d    = '0;
            end
        endcase
    end

    // Sticky logger: a fresh fault beats a simultaneous clear.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_wr_d   = fault_wr_q;
        if (new_fault && (!fault_q || fault_clr)) begin
            fault_d      = 1'b1;
            fault_addr_d = mem_addr;
            fault_wr_d   = new_fault_wr;
        end else if (fault_clr) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
            fault_wr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            cs_q         <= '0;
            din_sel_q    <= SEL_UNMAPPED;
            base_addr_q  <= '0;
            reg_rs_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_wr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            cs_q         <= cs_d;
            din_sel_q    <= din_sel_d;
            base_addr_q  <= base_addr_d;
            reg_rs_q     <= reg_rs_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_wr_q   <= fault_wr_d;
        end
    end

    assign mem_ready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign cs         = cs_q;
    assign din_sel    = din_sel_q;
    assign base_addr  = base_addr_q;
    assign reg_rs     = reg_rs_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign fault_wr   = fault_wr_q;

    cs_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cs_q));

endmodule

// File: tb/tb_mem_map_ws.sv
// Scoreboard bench for mem_map_ws: expected access results are queued as each
// request is driven and popped once the DUT has completed the access.
module tb_mem_map_ws;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic        fault_clr = 1'b0;
    logic        mem_ready;
    logic [1:0]  din_sel;
    logic [4:0]  cs;
    logic [14:0] base_addr;
    logic        reg_rs;
    logic        fault;
    logic [15:0] fault_addr;
    logic        fault_wr;

    int n_cmp = 0;
    int n_mis = 0;

    localparam int WIN = 8;

    typedef struct {
        logic [15:0] a;
        logic        we;
        logic        clr;
        int          lat;
        int          cs_cyc;
        logic [4:0]  cs;
        logic [1:0]  sel;
        logic [14:0] base;
        logic        rs;
        logic        flt;
        logic [15:0] faddr;
        logic        fwr;
    } exp_t;

    typedef struct {
        int          lat;
        int          rdy;
        int          cs_cyc;
        logic [4:0]  cs;
        logic [1:0]  sel;
        logic [14:0] base;
        logic        rs;
        logic        flt;
        logic [15:0] faddr;
        logic        fwr;
    } obs_t;

    exp_t sbq[$];

    mem_map_ws dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .din_sel    (din_sel),
        .cs         (cs),
        .base_addr  (base_addr),
        .reg_rs     (reg_rs),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fault_wr   (fault_wr),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [15:0] a, input logic we, input logic clr,
                                input int lat, input int cs_cyc, input logic [4:0] c,
                                input logic [1:0] sel, input logic [14:0] base, input logic rs,
                                input logic flt, input logic [15:0] faddr, input logic fwr);
        exp_t e;
        e.a = a; e.we = we; e.clr = clr; e.lat = lat; e.cs_cyc = cs_cyc; e.cs = c;
        e.sel = sel; e.base = base; e.rs = rs; e.flt = flt; e.faddr = faddr; e.fwr = fwr;
        return e;
    endfunction

    // Drives one request, then watches a fixed window of cycles; the address is
    // scrambled after acceptance and mem_valid drops once mem_ready is seen.
    task automatic drive(input logic [15:0] a, input logic we, input logic clr, output obs_t o);
        o.lat = 0; o.rdy = 0; o.cs_cyc = 0; o.cs = '0; o.sel = '0; o.base = '0; o.rs = 1'b0;
        @(negedge clk);
        mem_addr = a; mem_we = we; mem_valid = 1'b1; fault_clr = clr;
        @(posedge clk);
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (k == 1) begin
                fault_clr = 1'b0;
                mem_addr = ~a;
            end
            if (cs !== 5'b0) o.cs_cyc++;
            if (mem_ready === 1'b1) begin
                o.rdy++;
                if (o.rdy == 1) begin
                    o.lat = k; o.cs = cs; o.sel = din_sel; o.base = base_addr; o.rs = reg_rs;
                end
                mem_valid = 1'b0;
            end
        end
        mem_valid = 1'b0;
        mem_we = 1'b0;
        o.flt = fault; o.faddr = fault_addr; o.fwr = fault_wr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cs !== 5'b0 || mem_ready !== 1'b0 || din_sel !== 2'b11) begin
            n_mis++;
            $display("FAIL reset_ctl: cs=%b rdy=%b sel=%b, required cs=00000 rdy=0 sel=11", cs, mem_ready, din_sel);
        end
        n_cmp++;
        if (base_addr !== 15'h0 || reg_rs !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_addr: base=%h rs=%b, required base=0000 rs=0", base_addr, reg_rs);
        end
        n_cmp++;
        if (fault !== 1'b0 || fault_addr !== 16'h0 || fault_wr !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_fault: fault=%b addr=%h wr=%b, required 0/0000/0", fault, fault_addr, fault_wr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        exp_t e; obs_t o;
        sbq.push_back(mk(16'h1234, 0, 0, 1, 1, 5'b00010, 2'b00, 15'h1234, 0, 0, 16'h0000, 0));
        drive(16'h1234, 0, 0, o);
        e = sbq.pop_front();
        n_cmp++;
        if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
            n_mis++;
            $display("FAIL ram_timing: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
        end
        n_cmp++;
        if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
            n_mis++;
            $display("FAIL ram_data: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
        end
        n_cmp++;
        if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
            n_mis++;
            $display("FAIL ram_fault: fault=%b addr=%h wr=%b, required %b/%h/%b", o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
        end
    endtask

    task automatic test_uart_wait();
        exp_t e; obs_t o;
        sbq.push_back(mk(16'hF001, 0, 0, 3, 3, 5'b01000, 2'b10, 15'h7001, 1, 0, 16'h0000, 0));
        drive(16'hF001, 0, 0, o);
        e = sbq.pop_front();
        n_cmp++;
        if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
            n_mis++;
            $display("FAIL uart_timing: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
        end
        n_cmp++;
        if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
            n_mis++;
            $display("FAIL uart_data: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
        end
        n_cmp++;
        if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
            n_mis++;
            $display("FAIL uart_fault: fault=%b addr=%h wr=%b, required %b/%h/%b", o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
        end
    endtask

    task automatic test_unmapped();
        exp_t tbl[2]; exp_t e; obs_t o;
        tbl[0] = mk(16'h8000, 0, 0, 1, 0, 5'b00000, 2'b11, 15'h0000, 0, 1, 16'h8000, 0);
        tbl[1] = mk(16'h9000, 0, 0, 1, 0, 5'b00000, 2'b11, 15'h1000, 0, 1, 16'h8000, 0);
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(tbl[i]);
            drive(tbl[i].a, tbl[i].we, tbl[i].clr, o);
            e = sbq.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
                n_mis++;
                $display("FAIL unmapped_timing[%h]: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", e.a, o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
            end
            n_cmp++;
            if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
                n_mis++;
                $display("FAIL unmapped_data[%h]: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", e.a, o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
            end
            n_cmp++;
            if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
                n_mis++;
                $display("FAIL unmapped_fault[%h]: fault=%b addr=%h wr=%b, required %b/%h/%b", e.a, o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
            end
        end
    endtask

    task automatic test_ro_write();
        exp_t tbl[2]; exp_t e; obs_t o;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++;
        if (fault !== 1'b0 || fault_addr !== 16'h0 || fault_wr !== 1'b0) begin
            n_mis++;
            $display("FAIL fault_clear: fault=%b addr=%h wr=%b, required 0/0000/0", fault, fault_addr, fault_wr);
        end
        tbl[0] = mk(16'hA000, 1, 0, 1, 0, 5'b00000, 2'b11, 15'h2000, 0, 1, 16'hA000, 1);
        tbl[1] = mk(16'h7FFF, 1, 0, 1, 1, 5'b00010, 2'b00, 15'h7FFF, 1, 1, 16'hA000, 1);
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(tbl[i]);
            drive(tbl[i].a, tbl[i].we, tbl[i].clr, o);
            e = sbq.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
                n_mis++;
                $display("FAIL write_timing[%h]: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", e.a, o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
            end
            n_cmp++;
            if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
                n_mis++;
                $display("FAIL write_data[%h]: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", e.a, o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
            end
            n_cmp++;
            if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
                n_mis++;
                $display("FAIL write_fault[%h]: fault=%b addr=%h wr=%b, required %b/%h/%b", e.a, o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
            end
        end
    endtask

    task automatic test_boundaries();
        exp_t tbl[6]; exp_t e; obs_t o;
        tbl[0] = mk(16'h0FFF, 0, 0, 1, 1, 5'b00001, 2'b01, 15'h0FFF, 1, 1, 16'hA000, 1);
        tbl[1] = mk(16'h1000, 0, 0, 1, 1, 5'b00010, 2'b00, 15'h1000, 0, 1, 16'hA000, 1);
        tbl[2] = mk(16'hF7FF, 0, 0, 3, 3, 5'b01000, 2'b10, 15'h77FF, 1, 1, 16'hA000, 1);
        tbl[3] = mk(16'hF800, 0, 0, 1, 1, 5'b10000, 2'b01, 15'h7800, 0, 1, 16'hA000, 1);
        tbl[4] = mk(16'hFFFF, 0, 0, 1, 1, 5'b10000, 2'b01, 15'h7FFF, 1, 1, 16'hA000, 1);
        tbl[5] = mk(16'hC000, 0, 1, 1, 0, 5'b00000, 2'b11, 15'h4000, 0, 1, 16'hC000, 0);
        for (int i = 0; i < 6; i++) begin
            sbq.push_back(tbl[i]);
            drive(tbl[i].a, tbl[i].we, tbl[i].clr, o);
            e = sbq.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
                n_mis++;
                $display("FAIL bound_timing[%h]: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", e.a, o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
            end
            n_cmp++;
            if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
                n_mis++;
                $display("FAIL bound_data[%h]: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", e.a, o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
            end
            n_cmp++;
            if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
                n_mis++;
                $display("FAIL bound_fault[%h]: fault=%b addr=%h wr=%b, required %b/%h/%b", e.a, o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        exp_t e; obs_t o;
        @(negedge clk);
        mem_addr = 16'hF001; mem_we = 1'b0; mem_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (cs !== 5'b01000 || mem_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_pre: cs=%b rdy=%b, required cs=01000 rdy=0", cs, mem_ready);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cs !== 5'b0 || mem_ready !== 1'b0 || din_sel !== 2'b11 || fault !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_async: cs=%b rdy=%b sel=%b fault=%b, required cs=00000 rdy=0 sel=11 fault=0", cs, mem_ready, din_sel, fault);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        rst_n = 1'b1;
        sbq.push_back(mk(16'h0000, 0, 0, 1, 1, 5'b00001, 2'b01, 15'h0000, 0, 0, 16'h0000, 0));
        drive(16'h0000, 0, 0, o);
        e = sbq.pop_front();
        n_cmp++;
        if (o.lat !== e.lat || o.rdy !== 1 || o.cs_cyc !== e.cs_cyc) begin
            n_mis++;
            $display("FAIL postrst_timing: lat=%0d rdy=%0d cs_cyc=%0d, required lat=%0d rdy=1 cs_cyc=%0d", o.lat, o.rdy, o.cs_cyc, e.lat, e.cs_cyc);
        end
        n_cmp++;
        if ({o.cs, o.sel, o.base, o.rs} !== {e.cs, e.sel, e.base, e.rs}) begin
            n_mis++;
            $display("FAIL postrst_data: cs=%b sel=%b base=%h rs=%b, required cs=%b sel=%b base=%h rs=%b", o.cs, o.sel, o.base, o.rs, e.cs, e.sel, e.base, e.rs);
        end
        n_cmp++;
        if ({o.flt, o.faddr, o.fwr} !== {e.flt, e.faddr, e.fwr}) begin
            n_mis++;
            $display("FAIL postrst_fault: fault=%b addr=%h wr=%b, required %b/%h/%b", o.flt, o.faddr, o.fwr, e.flt, e.faddr, e.fwr);
        end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_uart_wait();
        test_unmapped();
        test_ro_write();
        test_boundaries();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_map_ws.md
Name: mem_map_ws

Overview:
- Parametrised, registered address decoder for the CH101/UK101 6502 bus. It replaces the fixed combinational map.
- Supports NREG base/limit regions, each with:
  - a din_sel code,
  - a per-region wait-state count,
  - a read-only attribute.
- Drives one-hot chip selects and a mem_ready handshake to the CPU-side bus controller.
- Latches a sticky fault (address and type) on unmapped accesses and on writes to read-only regions.

Parameters:
- ADDR_W, 16, CPU address width.
- NREG, 5, number of regions (1..8).
- SEL_W, 2, din_sel width. Code 2^SEL_W-1 is reserved for "unmapped".
- REG_LO, {F800,F000,A000,1000,0000}, packed NREG*ADDR_W inclusive lower bounds. Region 0 is in the LSBs.
- REG_HI, {FFFF,F7FF,BFFF,7FFF,0FFF}, packed NREG*ADDR_W inclusive upper bounds.
- REG_SEL, {01,10,01,00,01}, packed NREG*SEL_W din_sel code per region.
- REG_WS, {0,2,0,0,0}, packed NREG*4 wait states per region (0..15).
- REG_RO, 5'b10101, read-only bit per region.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  ADDR_W  CPU address
- mem_valid  in  1  access request; held high until mem_ready
- mem_we  in  1  1 = write
- mem_ready  out  1  one-cycle access-complete pulse
- din_sel  out  SEL_W  registered read-mux select
- cs  out  NREG  registered one-hot chip selects
- base_addr  out  ADDR_W-1  registered mem_addr[ADDR_W-2:0]
- reg_rs  out  1  registered mem_addr[0] (UART RS)
- fault  out  1  sticky fault flag
- fault_addr  out  ADDR_W  address of the first fault
- fault_wr  out  1  1 = RO-write violation, 0 = unmapped
- fault_clr  in  1  clears fault, fault_addr and fault_wr

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state=IDLE
  - cs=0, mem_ready=0, din_sel=all-ones, base_addr=0, reg_rs=0
  - fault=0, fault_addr=0, fault_wr=0
- Decode:
  - Region r hits when REG_LO[r] <= mem_addr <= REG_HI[r].
  - On overlapping hits, the lowest index wins.
  - No hit means unmapped.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: when mem_valid=1 at edge T0, register din_sel/base_addr/reg_rs, load wcnt=REG_WS[r], then:
    - mapped and permitted: cs[r]=1 from T0+1.
    - unmapped, or mem_we=1 to an RO region: cs stays 0, din_sel=all-ones, fault is set, and fault_wr is set accordingly.
    - Go to ACCESS.
  - ACCESS: if wcnt==0, mem_ready=1 this cycle and go to DONE; otherwise decrement wcnt.
    - Faulted accesses use wcnt=0.
  - DONE: cs=0, mem_ready=0, go to IDLE.
    - din_sel/base_addr hold their values until the next accept.
- Latency:
  - mem_ready is high exactly in cycle T0+1+WS, for exactly one cycle.
  - cs is high for cycles T0+1 .. T0+1+WS.
  - The next request is accepted no earlier than edge T0+3+WS, in IDLE.
- mem_valid and mem_addr are ignored outside IDLE. The request is captured once; address changes during the access have no effect.
- Fault logging:
  - The fault is sticky.
  - fault_addr and fault_wr capture only the first fault after a clear.
  - Later faults are not logged while fault=1.
  - A new fault and fault_clr in the same cycle: the fault wins, and the new address and type are captured.
- Wrap-around: mem_addr=FFFF is a legal address inside region 4; there is no off-by-one at the REG_HI boundaries.
- cs is always one-hot or zero. Assertion: $onehot0(cs), checked in simulation.

Decomposition:
- Package ch101_map_pkg holds:
  - the state enum (IDLE/ACCESS/DONE),
  - the SEL codes (SEL_RAM=00, SEL_ROM=01, SEL_UART=10, SEL_NONE=11),
  - the default UK101 region constants.
- Sub-module mem_map_dec: a purely combinational priority region match producing hit, idx and ro.
- mem_map_ws holds the FSM, the wait counter, the output registers and the fault logger.

Test Plan:
- Read 0x1234 with mem_valid → din_sel=00 and cs=00010 at T0+1, mem_ready at T0+1, base_addr=0x1234.
- Read 0xF001 (UART, WS=2) → cs=01000 for cycles T0+1..T0+3, mem_ready only at T0+3, reg_rs=1, din_sel=10.
- Read 0x8000 (unmapped) → cs=0, din_sel=11, mem_ready at T0+1, fault=1, fault_addr=0x8000, fault_wr=0. A later read of 0x9000 leaves fault_addr=0x8000.
- Write 0xA000 (RO BASIC) → no cs, mem_ready at T0+1, fault_wr=1. Write 0x7FFF → cs[1]=1, no fault.
- Boundaries: reads of 0x0FFF, 0x1000, 0xF7FF, 0xF800 and 0xFFFF → cs[0], cs[1], cs[3], cs[4] and cs[4] respectively. Also pulse fault_clr in the same cycle a new fault is set → fault stays 1 with the new address.
- Assert rst_n low during the UART wait cycle T0+2 → cs=0 and mem_ready=0 immediately. After release, a read of 0x0000 completes normally.
